// File: rtl/exception_ctrl_if.sv
// Exception controller bundle: per-source requests and eret in, flush/redirect/status out.
// exc_count (and CNT_W) exist only when EXC_COUNT_EN is defined.
interface exception_ctrl_if #(
    parameter int unsigned PC_W    = 32,
    parameter int unsigned NUM_SRC = 4
`ifdef EXC_COUNT_EN
   ,parameter int unsigned CNT_W   = 8
`endif
);
    localparam int unsigned CAUSE_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    logic [NUM_SRC-1:0]      exc_req;
    logic [NUM_SRC*PC_W-1:0] exc_pc;
    logic                    eret;
    logic                    if_flush;
    logic                    id_flush;
    logic                    ex_flush;
    logic                    pc_redirect;
    logic [PC_W-1:0]         redirect_addr;
    logic [PC_W-1:0]         epc;
    logic [CAUSE_W-1:0]      cause;
    logic                    exc_active;
    logic                    exc_lost;
`ifdef EXC_COUNT_EN
    logic [NUM_SRC*CNT_W-1:0] exc_count;

    modport master (
        output exc_req, exc_pc, eret,
        input  if_flush, id_flush, ex_flush, pc_redirect, redirect_addr,
               epc, cause, exc_active, exc_lost, exc_count
    );
    modport slave (
        input  exc_req, exc_pc, eret,
        output if_flush, id_flush, ex_flush, pc_redirect, redirect_addr,
               epc, cause, exc_active, exc_lost, exc_count
    );
`else
    modport master (
        output exc_req, exc_pc, eret,
        input  if_flush, id_flush, ex_flush, pc_redirect, redirect_addr,
               epc, cause, exc_active, exc_lost
    );
    modport slave (
        input  exc_req, exc_pc, eret,
        output if_flush, id_flush, ex_flush, pc_redirect, redirect_addr,
               epc, cause, exc_active, exc_lost
    );
`endif
endinterface

// File: rtl/exception_ctrl_unit.sv
// Exception sequencer: arbitrates sources, captures EPC/Cause, runs flush -> redirect -> handler -> return.
// Optional per-source saturating acceptance counters under EXC_COUNT_EN.
module exception_ctrl_unit #(
    parameter int unsigned     PC_W         = 32,
    parameter int unsigned     NUM_SRC      = 4,
    parameter logic [PC_W-1:0] HANDLER_ADDR = PC_W'(32'h8000_0180),
    parameter int unsigned     FLUSH_CYC    = 2
`ifdef EXC_COUNT_EN
   ,parameter int unsigned     CNT_W        = 8
`endif
) (
    input  logic              clk,
    input  logic              rst_n,
    exception_ctrl_if.slave   bus
);
    localparam int unsigned     CAUSE_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
    localparam int unsigned     FC_W    = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;
    localparam logic [FC_W-1:0] FC_LAST = FC_W'(FLUSH_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_FLUSH, S_REDIRECT, S_HANDLER, S_RETURN
    } state_t;

    state_t              state, state_nxt;
    logic [FC_W-1:0]     flush_cnt, flush_cnt_nxt;
    logic [PC_W-1:0]     epc_q, epc_nxt;
    logic [CAUSE_W-1:0]  cause_q, cause_nxt;
    logic                lost_q, lost_nxt;
    logic [PC_W-1:0]     addr_q, addr_nxt;
    logic                if_q, if_nxt;
    logic                idex_q, idex_nxt;
    logic                redir_q, redir_nxt;
    logic                active_q, active_nxt;
    logic [CAUSE_W-1:0]  win_idx;
    logic [PC_W-1:0]     win_pc;
    logic                any_req;

    // Fixed priority: lowest set index wins.
    always_comb begin
        win_idx = '0;
        win_pc  = '0;
        for (int i = int'(NUM_SRC) - 1; i >= 0; i--) begin
            if (bus.exc_req[i]) begin
                win_idx = CAUSE_W'(i);
                win_pc  = bus.exc_pc[i*PC_W +: PC_W];
            end
        end
    end

    assign any_req = |bus.exc_req;

    always_comb begin
        state_nxt     = state;
        flush_cnt_nxt = flush_cnt;
        epc_nxt       = epc_q;
        cause_nxt     = cause_q;
        lost_nxt      = lost_q;
        if_nxt        = 1'b0;
        idex_nxt      = 1'b0;
        redir_nxt     = 1'b0;
        active_nxt    = 1'b0;
        addr_nxt      = '0;

        case (state)
            S_IDLE: begin
                if (any_req) begin
                    state_nxt     = S_FLUSH;
                    flush_cnt_nxt = '0;
                    epc_nxt       = win_pc;
                    cause_nxt     = win_idx;
                end
            end
            S_FLUSH: begin
                if (flush_cnt == FC_LAST) begin
                    state_nxt     = S_REDIRECT;
                    flush_cnt_nxt = '0;
                end else begin
                    flush_cnt_nxt = flush_cnt + FC_W'(1);
                end
            end
            S_REDIRECT: state_nxt = S_HANDLER;
            S_HANDLER: begin
                if (bus.eret) state_nxt = S_RETURN;
            end
            S_RETURN: begin
                state_nxt = S_IDLE;
                lost_nxt  = 1'b0;
            end
            default: state_nxt = S_IDLE;
        endcase

        // A request that cannot be taken is recorded; this beats the return-edge clear.
        if (any_req && (state != S_IDLE)) lost_nxt = 1'b1;

        // Outputs decoded from the next state so every output leaves a flop.
        case (state_nxt)
            S_FLUSH: begin
                if_nxt     = 1'b1;
                idex_nxt   = 1'b1;
                active_nxt = 1'b1;
            end
            S_REDIRECT: begin
                if_nxt     = 1'b1;
                redir_nxt  = 1'b1;
                addr_nxt   = HANDLER_ADDR;
                active_nxt = 1'b1;
            end
            S_HANDLER: active_nxt = 1'b1;
            S_RETURN: begin
                if_nxt     = 1'b1;
                redir_nxt  = 1'b1;
                addr_nxt   = epc_nxt;
                active_nxt = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            flush_cnt <= '0;
            epc_q     <= '0;
            cause_q   <= '0;
            lost_q    <= 1'b0;
            addr_q    <= '0;
            if_q      <= 1'b0;
            idex_q    <= 1'b0;
            redir_q   <= 1'b0;
            active_q  <= 1'b0;
        end else begin
            state     <= state_nxt;
            flush_cnt <= flush_cnt_nxt;
            epc_q     <= epc_nxt;
            cause_q   <= cause_nxt;
            lost_q    <= lost_nxt;
            addr_q    <= addr_nxt;
            if_q      <= if_nxt;
            idex_q    <= idex_nxt;
            redir_q   <= redir_nxt;
            active_q  <= active_nxt;
        end
    end

    assign bus.if_flush      = if_q;
    assign bus.id_flush      = idex_q;
    assign bus.ex_flush      = idex_q;
    assign bus.pc_redirect   = redir_q;
    assign bus.redirect_addr = addr_q;
    assign bus.epc           = epc_q;
    assign bus.cause         = cause_q;
    assign bus.exc_active    = active_q;
    assign bus.exc_lost      = lost_q;

`ifdef EXC_COUNT_EN
    logic [NUM_SRC-1:0][CNT_W-1:0] cnt_q;

    // Counts accepted exceptions only; saturates at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if ((state == S_IDLE) && any_req && (cnt_q[win_idx] != '1)) begin
            cnt_q[win_idx] <= cnt_q[win_idx] + CNT_W'(1);
        end
    end

    assign bus.exc_count = cnt_q;
`endif
endmodule
